// File: rtl/matmul_arbiter_if.sv
// Handshake/bus bundle between matmul_arbiter, its two requesters,
// the shared matmul unit and the result consumer.
interface matmul_arbiter_if #(
  parameter int SEL_W = 4
);
  logic [1:0]       req;
  logic [1:0]       grant;
  logic             src_sel;
  logic [1:0]       done;
  logic             err;
  logic             mm_start;
  logic             mm_ready;
  logic [SEL_W-1:0] mm_sel;
  logic [15:0]      mm_data;
  logic             res_valid;
  logic             res_ready;
  logic [15:0]      res_data;
  logic [SEL_W-1:0] res_idx;

  modport master (
    input  req, mm_ready, mm_data, res_ready,
    output grant, src_sel, done, err, mm_start,
    output mm_sel, res_valid, res_data, res_idx
  );

  modport slave (
    output req, mm_ready, mm_data, res_ready,
    input  grant, src_sel, done, err, mm_start,
    input  mm_sel, res_valid, res_data, res_idx
  );
endinterface

// File: rtl/matmul_arbiter.sv
// Round-robin sharing of one matmul unit between two requesters.
// Define MATMUL_ARB_TIMEOUT_EN to build in the WAIT watchdog.
module matmul_arbiter #(
  parameter int OUT_LEN        = 4,
  parameter int SEL_W          = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                clk,
  input logic                rst,
  matmul_arbiter_if.master   bus
);
  typedef enum logic [2:0] {
    IDLE, LAUNCH, ARM, WAIT, DRAIN, DONE
  } state_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(OUT_LEN - 1);

  state_t           state;
  logic             prio;
  logic             owner;
  logic [1:0]       grant;
  logic [1:0]       done;
  logic             start;
  logic             vld;
  logic [SEL_W-1:0] idx;
  logic             win;
  logic             hs;

`ifdef MATMUL_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] timer;
  logic          err_q;
`endif

  // Favour the requester not served last; fall back to the other.
  assign win = bus.req[prio] ? prio : ~prio;
  assign hs  = vld & bus.res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      prio  <= 1'b0;
      owner <= 1'b0;
      grant <= 2'b00;
      done  <= 2'b00;
      start <= 1'b0;
      vld   <= 1'b0;
      idx   <= '0;
`ifdef MATMUL_ARB_TIMEOUT_EN
      timer <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      start <= 1'b0;
      done  <= 2'b00;
`ifdef MATMUL_ARB_TIMEOUT_EN
      err_q <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            owner <= win;
            grant <= win ? 2'b10 : 2'b01;
            start <= 1'b1;
            state <= LAUNCH;
`ifdef MATMUL_ARB_TIMEOUT_EN
            timer <= '0;
`endif
          end
        end
        LAUNCH: state <= ARM;
        ARM: begin
          state <= WAIT;
`ifdef MATMUL_ARB_TIMEOUT_EN
          timer <= timer + 1'b1;
`endif
        end
        WAIT: begin
          if (bus.mm_ready) begin
            idx   <= '0;
            vld   <= 1'b1;
            state <= DRAIN;
          end
`ifdef MATMUL_ARB_TIMEOUT_EN
          else if (timer == TLIM) begin
            err_q <= 1'b1;
            grant <= 2'b00;
            prio  <= ~owner;
            state <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
`endif
        end
        DRAIN: begin
          if (hs) begin
            if (idx == LAST) begin
              idx   <= '0;
              vld   <= 1'b0;
              done  <= grant;
              state <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          grant <= 2'b00;
          prio  <= ~owner;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant     = grant;
  assign bus.src_sel   = owner;
  assign bus.done      = done;
  assign bus.mm_start  = start;
  assign bus.mm_sel    = idx;
  assign bus.res_idx   = idx;
  assign bus.res_valid = vld;
  assign bus.res_data  = bus.mm_data;

`ifdef MATMUL_ARB_TIMEOUT_EN
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_matmul_arbiter.sv
// Scoreboard bench for matmul_arbiter with a behavioural matmul model.
// Build with MATMUL_ARB_TIMEOUT_EN to exercise the watchdog path.
module tb_matmul_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matmul_arbiter_if #(.SEL_W(4)) bus();

  matmul_arbiter #(
    .OUT_LEN(4),
    .SEL_W(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [3:0]  idx;
    logic [15:0] data;
  } exp_t;

  exp_t       sb[$];
  exp_t       me;
  int         checks = 0;
  int         fails  = 0;
  int         lat    = 3;
  int         cnt    = 0;
  logic [7:0] tag    = 8'h00;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Element value encodes owner, job tag and column index.
  assign bus.mm_data = {3'b000, bus.src_sel, tag, bus.mm_sel};

  // matmul model: drops ready on start, raises it lat cycles later.
  initial begin
    bus.mm_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.mm_start) begin
        bus.mm_ready = 1'b0;
        cnt = lat;
      end else if (!bus.mm_ready && cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.mm_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) begin
          chk("sb_extra", 1, 0);
        end else begin
          me = sb.pop_front();
          chk("res_idx", bus.res_idx, me.idx);
          chk("res_data", bus.res_data, me.data);
        end
      end
      if (!bus.res_valid && bus.grant != 2'b00)
        chk("mm_sel_idle", bus.mm_sel, 0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_job(input logic o, input logic [7:0] t);
    tag = t;
    for (int i = 0; i < 4; i++)
      sb.push_back('{4'(i), {3'b000, o, t, 4'(i)}});
  endtask

  task automatic wait_grant(input logic [1:0] g, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.grant == 2'b00 && n < 50);
    if (bus.grant == 2'b00) begin
      chk("grant_timeout", 0, 1);
    end else begin
      chk("grant", bus.grant, g);
      chk("src_sel", bus.src_sel, g[1]);
    end
  endtask

  task automatic wait_done(input logic [1:0] d, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.done == 2'b00 && n < 100);
    if (bus.done == 2'b00) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("done", bus.done, d);
      chk("sb_empty", sb.size(), 0);
    end
  endtask

  initial begin
    int n;
    int pat[6]  = '{1, 0, 0, 1, 1, 1};
    int eidx[6] = '{0, 1, 1, 1, 2, 3};
    logic seen;

    rst = 1'b1;
    bus.req = 2'b11;
    bus.res_ready = 1'b1;
    repeat (2) tick();
    chk("rst_grant", bus.grant, 0);
    chk("rst_src_sel", bus.src_sel, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_mm_start", bus.mm_start, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_idx", bus.res_idx, 0);
    chk("rst_mm_sel", bus.mm_sel, 0);

    // Both request after reset: req[0] first, then req[1].
    push_job(1'b0, 8'h11);
    @(negedge clk) rst = 1'b0;
    wait_grant(2'b01, n);
    chk("grant_lat", n, 1);
    chk("mm_start_on", bus.mm_start, 1);
    tick();
    chk("mm_start_off", bus.mm_start, 0);
    chk("grant_held", bus.grant, 2'b01);
    wait_done(2'b01, n);
    push_job(1'b1, 8'h22);
    wait_grant(2'b10, n);
    bus.req = 2'b00;
    wait_done(2'b10, n);

    // Only req[1], slow matmul.
    lat = 8;
    bus.req = 2'b10;
    push_job(1'b1, 8'h33);
    wait_grant(2'b10, n);
    bus.req = 2'b00;
    wait_done(2'b10, n);
    chk("job_len_lat8", n, 13);
    lat = 3;

    // Backpressure pattern on the result port.
    bus.req = 2'b01;
    push_job(1'b0, 8'h44);
    wait_grant(2'b01, n);
    bus.req = 2'b00;
    n = 0;
    while (!bus.res_valid && n < 50) begin
      tick();
      n++;
    end
    chk("valid_seen", bus.res_valid, 1);
    for (int i = 0; i < 6; i++) begin
      bus.res_ready = pat[i][0];
      chk("idx_seq", bus.res_idx, eidx[i]);
      tick();
    end
    chk("done_bp", bus.done, 2'b01);
    chk("sb_empty_bp", sb.size(), 0);
    bus.res_ready = 1'b1;

    // Request withdrawn right after the grant.
    bus.req = 2'b01;
    push_job(1'b0, 8'h55);
    wait_grant(2'b01, n);
    tick();
    bus.req = 2'b00;
    wait_done(2'b01, n);

    // Reset in WAIT aborts the job.
    lat = 0;
    bus.req = 2'b01;
    wait_grant(2'b01, n);
    bus.req = 2'b00;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    chk("mid_grant", bus.grant, 0);
    chk("mid_src_sel", bus.src_sel, 0);
    chk("mid_done", bus.done, 0);
    chk("mid_err", bus.err, 0);
    chk("mid_mm_start", bus.mm_start, 0);
    chk("mid_res_valid", bus.res_valid, 0);
    chk("mid_res_idx", bus.res_idx, 0);
    chk("mid_mm_sel", bus.mm_sel, 0);
    lat = 3;
    bus.req = 2'b10;
    push_job(1'b1, 8'h66);
    @(negedge clk) rst = 1'b0;
    wait_grant(2'b10, n);
    chk("post_rst_lat", n, 1);
    bus.req = 2'b00;
    wait_done(2'b10, n);

    // matmul never becomes ready.
    lat = 0;
    bus.req = 2'b01;
    wait_grant(2'b01, n);
    bus.req = 2'b00;
`ifdef MATMUL_ARB_TIMEOUT_EN
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.err && n < 40);
    chk("err_lat", n, 17);
    chk("err_grant", bus.grant, 0);
    chk("err_done", bus.done, 0);
    tick();
    chk("err_pulse", bus.err, 0);
`else
    seen = 1'b0;
    repeat (1000) begin
      tick();
      if (bus.err || bus.done != 2'b00) seen = 1'b1;
    end
    chk("hang_seen", seen, 0);
    chk("hang_grant", bus.grant, 2'b01);
    chk("hang_valid", bus.res_valid, 0);
`endif
    rst = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
